// File: rtl/bcpu_thread_pkg.sv
// Shared thread-id and per-thread state types for the barrel CPU issue logic.
package bcpu_thread_pkg;
  localparam int THREAD_W    = 2;
  localparam int NUM_THREADS = 2 ** THREAD_W;

  typedef logic [THREAD_W-1:0] thread_id_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2,
    HALT = 2'd3
  } thread_state_e;
endpackage

// File: rtl/thread_slot.sv
// One hardware thread: run-state register and program counter.
// fire marks a fetch leaving this thread; err flags a start/response it must ignore.
module thread_slot
  import bcpu_thread_pkg::*;
#(
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter bit              RESET_RUN = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sel,
  input  logic            start,
  input  logic [PC_W-1:0] start_pc,
  input  logic            rsp,
  input  logic            halt,
  input  logic [PC_W-1:0] rsp_next_pc,
  output thread_state_e   state,
  output logic [PC_W-1:0] pc,
  output logic            fire,
  output logic            err
);

  thread_state_e   state_nxt;
  logic [PC_W-1:0] pc_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RESET_RUN ? RUN : IDLE;
      pc    <= RESET_RUN ? RESET_PC : '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    fire      = 1'b0;
    err       = 1'b0;
    unique case (state)
      IDLE, HALT: begin
        err = rsp;
        if (start) begin
          state_nxt = RUN;
          pc_nxt    = start_pc;
        end
      end
      RUN: begin
        err = start | rsp;
        if (sel) begin
          state_nxt = WAIT;
          fire      = 1'b1;
        end
      end
      WAIT: begin
        // A response landing on this thread's slot only re-arms it; the fetch waits a full rotation.
        err = start;
        if (rsp) begin
          state_nxt = halt ? HALT : RUN;
          pc_nxt    = rsp_next_pc;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/thread_issue_ctrl.sv
// Barrel-CPU fetch issue: picks the timer's thread when it is runnable and
// registers the fetch request; keeps one instruction in flight per thread.
module thread_issue_ctrl
  import bcpu_thread_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  thread_id_t             thread_timer_data,
  input  logic                   start_valid,
  input  thread_id_t             start_thread,
  input  logic [PC_W-1:0]        start_pc,
  input  logic                   rsp_valid,
  input  thread_id_t             rsp_thread,
  input  logic [PC_W-1:0]        rsp_next_pc,
  input  logic                   rsp_halt,
  output logic                   issue_valid,
  output thread_id_t             issue_thread,
  output logic [PC_W-1:0]        issue_pc,
  output logic [NUM_THREADS-1:0] thread_active,
  output logic                   proto_err
);

  thread_state_e          st   [NUM_THREADS];
  logic [PC_W-1:0]        pcs  [NUM_THREADS];
  logic [NUM_THREADS-1:0] fire;
  logic [NUM_THREADS-1:0] err;

  for (genvar i = 0; i < NUM_THREADS; i++) begin : g_slot
    thread_slot #(
      .PC_W      (PC_W),
      .RESET_PC  (RESET_PC),
      .RESET_RUN (i == 0)
    ) u_slot (
      .clk         (clk),
      .rst         (rst),
      .sel         (thread_timer_data == thread_id_t'(i)),
      .start       (start_valid && (start_thread == thread_id_t'(i))),
      .start_pc    (start_pc),
      .rsp         (rsp_valid && (rsp_thread == thread_id_t'(i))),
      .halt        (rsp_halt),
      .rsp_next_pc (rsp_next_pc),
      .state       (st[i]),
      .pc          (pcs[i]),
      .fire        (fire[i]),
      .err         (err[i])
    );

    assign thread_active[i] = (st[i] == RUN) || (st[i] == WAIT);
  end

  // Issue register: thread/pc hold their last values on idle slots.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_valid  <= 1'b0;
      issue_thread <= '0;
      issue_pc     <= '0;
      proto_err    <= 1'b0;
    end else begin
      issue_valid <= |fire;
      if (|fire) begin
        issue_thread <= thread_timer_data;
        issue_pc     <= pcs[thread_timer_data];
      end
      proto_err <= proto_err | (|err);
    end
  end

endmodule

// File: tb/tb_thread_issue_ctrl.sv
// Bench for thread_issue_ctrl: directed vector table plus multi-thread and reset sequences,
// expectations queued at drive time and compared after each clock edge.
module tb_thread_issue_ctrl;
  import bcpu_thread_pkg::*;

  localparam int          PC_W     = 32;
  localparam logic [31:0] RST_PC   = 32'h0000_1000;

  typedef struct {
    logic        rst;
    logic [1:0]  tm;
    logic        sv;
    logic [1:0]  st;
    logic [31:0] spc;
    logic        rv;
    logic [1:0]  rt;
    logic [31:0] rpc;
    logic        rh;
    logic        ev;
    logic [1:0]  et;
    logic [31:0] epc;
    logic [3:0]  eact;
    logic        eerr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  thread_id_t  thread_timer_data;
  logic        start_valid;
  thread_id_t  start_thread;
  logic [31:0] start_pc;
  logic        rsp_valid;
  thread_id_t  rsp_thread;
  logic [31:0] rsp_next_pc;
  logic        rsp_halt;
  logic        issue_valid;
  thread_id_t  issue_thread;
  logic [31:0] issue_pc;
  logic [3:0]  thread_active;
  logic        proto_err;

  int tests = 0;
  int fails = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  thread_issue_ctrl #(.PC_W(PC_W), .RESET_PC(RST_PC)) dut (
    .clk               (clk),
    .rst               (rst),
    .thread_timer_data (thread_timer_data),
    .start_valid       (start_valid),
    .start_thread      (start_thread),
    .start_pc          (start_pc),
    .rsp_valid         (rsp_valid),
    .rsp_thread        (rsp_thread),
    .rsp_next_pc       (rsp_next_pc),
    .rsp_halt          (rsp_halt),
    .issue_valid       (issue_valid),
    .issue_thread      (issue_thread),
    .issue_pc          (issue_pc),
    .thread_active     (thread_active),
    .proto_err         (proto_err)
  );

  function automatic vec_t mk(logic r, logic [1:0] tm,
                              logic sv, logic [1:0] st, logic [31:0] spc,
                              logic rv, logic [1:0] rt, logic [31:0] rpc, logic rh,
                              logic ev, logic [1:0] et, logic [31:0] epc,
                              logic [3:0] act, logic err);
    vec_t v;
    v.rst = r;   v.tm = tm;
    v.sv = sv;   v.st = st;   v.spc = spc;
    v.rv = rv;   v.rt = rt;   v.rpc = rpc;  v.rh = rh;
    v.ev = ev;   v.et = et;   v.epc = epc;  v.eact = act; v.eerr = err;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    rst               = v.rst;
    thread_timer_data = v.tm;
    start_valid       = v.sv;
    start_thread      = v.st;
    start_pc          = v.spc;
    rsp_valid         = v.rv;
    rsp_thread        = v.rt;
    rsp_next_pc       = v.rpc;
    rsp_halt          = v.rh;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("issue_valid",   idx, 32'(issue_valid),   32'(e.ev));
    chk("issue_thread",  idx, 32'(issue_thread),  32'(e.et));
    chk("issue_pc",      idx, issue_pc,           e.epc);
    chk("thread_active", idx, 32'(thread_active), 32'(e.eact));
    chk("proto_err",     idx, 32'(proto_err),     32'(e.eerr));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] base [4];
    int step;
    rst = 1'b1; thread_timer_data = '0; start_valid = 1'b0; start_thread = '0;
    start_pc = '0; rsp_valid = 1'b0; rsp_thread = '0; rsp_next_pc = '0; rsp_halt = 1'b0;

    // rst tm | start v,t,pc | rsp v,t,pc,halt | exp valid,thread,pc,active,err
    tbl.push_back(mk(1,0, 0,0,0,     0,0,0,0,        0,0,0,     4'h1,0));
    tbl.push_back(mk(0,0, 0,0,0,     0,0,0,0,        1,0,RST_PC,4'h1,0));
    tbl.push_back(mk(0,1, 0,0,0,     0,0,0,0,        0,0,RST_PC,4'h1,0));
    tbl.push_back(mk(0,2, 0,0,0,     1,0,32'h4,0,    0,0,RST_PC,4'h1,0));
    tbl.push_back(mk(0,3, 0,0,0,     0,0,0,0,        0,0,RST_PC,4'h1,0));
    tbl.push_back(mk(0,0, 0,0,0,     0,0,0,0,        1,0,32'h4, 4'h1,0));
    tbl.push_back(mk(0,1, 0,0,0,     0,0,0,0,        0,0,32'h4, 4'h1,0));
    tbl.push_back(mk(0,2, 0,0,0,     1,0,32'h8,0,    0,0,32'h4, 4'h1,0));
    tbl.push_back(mk(0,3, 0,0,0,     0,0,0,0,        0,0,32'h4, 4'h1,0));
    tbl.push_back(mk(0,0, 0,0,0,     0,0,0,0,        1,0,32'h8, 4'h1,0));
    tbl.push_back(mk(0,1, 0,0,0,     1,0,32'hC,0,    0,0,32'h8, 4'h1,0));
    tbl.push_back(mk(0,2, 1,2,32'h100, 0,0,0,0,      0,0,32'h8, 4'h5,0));
    tbl.push_back(mk(0,3, 0,0,0,     0,0,0,0,        0,0,32'h8, 4'h5,0));
    tbl.push_back(mk(0,0, 0,0,0,     0,0,0,0,        1,0,32'hC, 4'h5,0));
    tbl.push_back(mk(0,1, 0,0,0,     0,0,0,0,        0,0,32'hC, 4'h5,0));
    tbl.push_back(mk(0,2, 0,0,0,     0,0,0,0,        1,2,32'h100,4'h5,0));
    tbl.push_back(mk(0,3, 0,0,0,     1,0,32'h10,1,   0,2,32'h100,4'h4,0));
    tbl.push_back(mk(0,0, 0,0,0,     0,0,0,0,        0,2,32'h100,4'h4,0));
    tbl.push_back(mk(0,1, 0,0,0,     1,2,32'h104,0,  0,2,32'h100,4'h4,0));
    tbl.push_back(mk(0,2, 1,0,32'h200, 0,0,0,0,      1,2,32'h104,4'h5,0));
    tbl.push_back(mk(0,3, 0,0,0,     0,0,0,0,        0,2,32'h104,4'h5,0));
    tbl.push_back(mk(0,0, 0,0,0,     0,0,0,0,        1,0,32'h200,4'h5,0));
    tbl.push_back(mk(0,1, 0,0,0,     1,1,32'h999,0,  0,0,32'h200,4'h5,1));
    tbl.push_back(mk(0,2, 1,0,32'h300, 0,0,0,0,      0,0,32'h200,4'h5,1));
    tbl.push_back(mk(0,3, 1,1,32'h400, 1,0,32'h204,0, 0,0,32'h200,4'h7,1));
    tbl.push_back(mk(0,0, 0,0,0,     0,0,0,0,        1,0,32'h204,4'h7,1));
    tbl.push_back(mk(0,1, 0,0,0,     0,0,0,0,        1,1,32'h400,4'h7,1));
    tbl.push_back(mk(0,2, 0,0,0,     1,2,32'h108,0,  0,1,32'h400,4'h7,1));
    tbl.push_back(mk(0,3, 0,0,0,     0,0,0,0,        0,1,32'h400,4'h7,1));
    tbl.push_back(mk(0,0, 0,0,0,     0,0,0,0,        0,1,32'h400,4'h7,1));
    tbl.push_back(mk(0,1, 0,0,0,     0,0,0,0,        0,1,32'h400,4'h7,1));
    tbl.push_back(mk(0,2, 0,0,0,     0,0,0,0,        1,2,32'h108,4'h7,1));
    tbl.push_back(mk(1,0, 0,0,0,     0,0,0,0,        0,0,0,     4'h1,0));

    step = 0;
    foreach (tbl[k]) begin
      apply(tbl[k], step);
      step++;
    end

    // All four threads streaming, each response returned two cycles after its issue.
    base[0] = RST_PC; base[1] = 32'h2000; base[2] = 32'h3000; base[3] = 32'h4000;
    for (int c = 0; c < 24; c++) begin
      vec_t v;
      logic [1:0] t;
      logic [3:0] act;
      t   = 2'(c % 4);
      act = (c == 0) ? 4'h3 : (c == 1) ? 4'h7 : 4'hF;
      v = mk(0, t, 0,0,0, 0,0,0,0, 1, t, base[t] + 32'(4 * (c / 4)), act, 0);
      if (c < 3) begin
        v.sv  = 1'b1;
        v.st  = 2'(c + 1);
        v.spc = base[c + 1];
      end
      if (c >= 2) begin
        v.rv  = 1'b1;
        v.rt  = 2'((c - 2) % 4);
        v.rpc = base[(c - 2) % 4] + 32'(4 * ((c - 2) / 4 + 1));
      end
      apply(v, step);
      step++;
    end

    // Reset mid-stream: in-flight work is dropped and late responses are protocol errors.
    apply(mk(1,0, 0,0,0, 0,0,0,0,          0,0,0,      4'h1,0), step++);
    apply(mk(0,1, 0,0,0, 1,1,32'h5555,0,   0,0,0,      4'h1,1), step++);
    apply(mk(0,2, 0,0,0, 1,0,32'h6666,0,   0,0,0,      4'h1,1), step++);
    apply(mk(0,3, 0,0,0, 0,0,0,0,          0,0,0,      4'h1,1), step++);
    apply(mk(0,0, 0,0,0, 0,0,0,0,          1,0,RST_PC, 4'h1,1), step++);
    apply(mk(1,1, 0,0,0, 0,0,0,0,          0,0,0,      4'h1,0), step++);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/thread_issue_ctrl.md
Name: thread_issue_ctrl

Overview:
- Consumer side of the 2-bit thread timer in the barrel CPU.
- Each cycle it reads the thread id from the timer and decides whether that thread issues a fetch.
- Holds per-thread PC and run state, and accepts next-PC/halt responses from the execute stage.
- Guarantees at most one instruction in flight per thread.

Parameters:
- PC_W, 32, program counter width.
- RESET_PC, 32'h0000_0000, PC loaded into thread 0 at reset.
- THREAD_W, 2, thread id width. Fixed to the timer width; NUM_THREADS = 2**THREAD_W = 4.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- thread_timer_data  input  THREAD_W  current thread slot from the thread timer
- start_valid  input  1  request to launch a thread
- start_thread  input  THREAD_W  thread to launch
- start_pc  input  PC_W  launch PC
- rsp_valid  input  1  execute-stage resolution of an in-flight instruction
- rsp_thread  input  THREAD_W  owning thread of the response
- rsp_next_pc  input  PC_W  next PC for that thread
- rsp_halt  input  1  thread executed halt
- issue_valid  output  1  fetch issued this cycle
- issue_thread  output  THREAD_W  thread of the issued fetch
- issue_pc  output  PC_W  fetch address
- thread_active  output  NUM_THREADS  bit i set when thread i is in RUN or WAIT
- proto_err  output  1  sticky protocol-violation flag

Behaviour:
- One clock (clk). Reset (rst) is synchronous and active-high.
- Per-thread state machine, states IDLE, RUN, WAIT, HALT:
  - IDLE/HALT --start_valid && start_thread==i--> RUN, with pc[i] <= start_pc.
  - RUN --slot selected (thread_timer_data==i)--> WAIT (issue).
  - WAIT --rsp_valid && rsp_thread==i && !rsp_halt--> RUN, with pc[i] <= rsp_next_pc.
  - WAIT --same response with rsp_halt--> HALT, with pc[i] <= rsp_next_pc.
- Reset values:
  - Thread 0 in RUN with pc0 = RESET_PC; threads 1-3 in IDLE with pc = 0.
  - issue_valid = 0, issue_thread = 0, issue_pc = 0, proto_err = 0.
  - thread_active = 4'b0001.
- Issue timing:
  - Registered, latency 1. State is sampled at edge N using thread_timer_data at N.
  - If the selected thread is RUN, then after edge N: issue_valid = 1, issue_thread = slot, issue_pc = pc[slot], and that thread is WAIT.
  - Otherwise issue_valid = 0 and issue_thread/issue_pc hold their last values.
- thread_active is registered and follows the state registers.
- Simultaneous events, all decisions use pre-edge state:
  - Response and slot for the same WAIT thread in one cycle: no issue this cycle. The thread becomes RUN and issues on its next slot, 4 cycles later.
  - Start and slot for the same IDLE thread: no issue; first issue on the next slot.
  - Start and response to different threads: both take effect.
- Protocol errors (each sets proto_err, sticky until rst):
  - start_valid to a thread in RUN/WAIT: ignored.
  - rsp_valid to a thread not in WAIT: ignored.
- Mid-operation reset: all in-flight instructions are forgotten and states return to reset values. Late responses after reset are protocol errors.
- The timer wraps 3 to 0 naturally. No assumption is made about ordering beyond the value on each cycle.

Decomposition:
- Package bcpu_thread_pkg:
  - THREAD_W, NUM_THREADS
  - thread_id_t
  - thread_state_e (IDLE, RUN, WAIT, HALT)
- Sub-module thread_slot, one instance per thread.
  - Contents: state register plus pc register.
  - Inputs: sel, start, rsp, halt.
  - Outputs: state, pc, fire, err.
- Top level holds the instance generate loop, the issue output mux/register, and the proto_err OR.

Test Plan:
- Reset, timer free-running 0,1,2,3,... → issue_valid pulses once (thread 0, pc = RESET_PC) one cycle after slot 0. thread_active = 0001. No further issues while there is no response.
- Response for thread 0 with next_pc 0x4 two cycles after issue → thread 0 issues pc 0x4 one cycle after its next slot 0. Repeated responses give 0x8, 0xC at a 4-cycle period.
- Start thread 2 at 0x100 while the timer is at 2 → no issue that cycle. Thread 2 issues 0x100 after its next slot, 4 cycles later. thread_active = 0101.
- Response for thread 0 with rsp_halt = 1 and next_pc 0x10 → thread 0 enters HALT, thread_active bit 0 clears. A later start of thread 0 at 0x200 relaunches it.
- Response for an IDLE thread, and start for a WAIT thread → both ignored, pc/state unchanged, proto_err = 1 and held until rst.
- All 4 threads running with responses returning within 3 cycles → issue_valid = 1 every cycle, issue_thread sequence 0,1,2,3,0,... Assert rst mid-stream → the next cycle matches reset values.
